ldpc_ber_sweep: RTL and testbench
=================================

Name: ldpc_ber_sweep

Overview:
Frame-based BER test controller for the LDPC decoder. It collects quantised LLRs from LANES noise lanes into a decoder frame and launches the decoder with a start/done handshake. It counts frame and bit errors against the all-zero codeword and steps the SNR index from snr_start to snr_stop, reporting one result record per SNR point. The next frame refills while the decoder runs.

Parameters:
DATA_W, 5, LLR width (signed)
FRAME_LEN, 2304, LLRs per frame; must be a multiple of LANES
LANES, 128, noise/quantiser lanes; LANE_DEPTH = FRAME_LEN/LANES
SNR_W, 4, SNR index width
CNT_W, 16, frame and frame-error counter width
BITERR_W, 24, bit-error counter width
MAX_FRAMES, 1000, frames decoded per SNR point
ERR_LIMIT, 100, frame-error early-stop threshold

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; begins a sweep when idle
snr_start  in  SNR_W  first SNR index, sampled on start
snr_stop  in  SNR_W  last SNR index, sampled on start
lane_valid  in  LANES  per-lane sample strobe
lane_llr  in  LANES*DATA_W  per-lane LLR; lane i at [i*DATA_W +: DATA_W]
lane_ce  out  LANES  per-lane noise-generator enable
snr_idx  out  SNR_W  current SNR index to the quantisers
dec_start  out  1  one-cycle decoder launch pulse
dec_llr  out  FRAME_LEN*DATA_W  frame held stable from dec_start until dec_done
dec_done  in  1  one-cycle pulse; dec_res and dec_err are valid in the same cycle
dec_res  in  FRAME_LEN  hard decisions
dec_err  in  1  decoder failed to converge
res_valid  out  1  one-cycle result pulse
res_snr  out  SNR_W  SNR of the record
res_frames  out  CNT_W  frames decoded
res_frame_errs  out  CNT_W  frame errors
res_bit_errs  out  BITERR_W  bit errors
busy  out  1  sweep in progress
done  out  1  high from sweep end until the next start

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high. Reset mid-operation aborts everything and returns the block to IDLE.
- Reset values: every output is 0; all counters, lane fill pointers and dec_llr are 0; state is IDLE.
- FSM states: IDLE, FILL, LAUNCH, DECODE, ACCUM, REPORT, NEXT, DONE.
- IDLE/DONE: on start, latch snr_start/snr_stop, set snr_idx = snr_start, clear counters and lanes, clear done, set busy, go to FILL. start is ignored while busy.
- Lane fill: each lane has a LANE_DEPTH-entry shift buffer and a fill count.
  - lane_ce[i] = busy & ~full[i].
  - A sample is accepted when lane_valid[i] & ~full[i].
  - Samples arriving while the lane is full are dropped.
  - Sample j (0 = first received) of lane i maps to dec_llr[(i*LANE_DEPTH+j)*DATA_W +: DATA_W].
- FILL: when every lane is full, go to LAUNCH.
  - This transition is blocked only while DECODE holds the previous frame; the lanes continue filling during DECODE.
- LAUNCH (1 cycle): copy the lane buffers to dec_llr, pulse dec_start, clear all lane fill counts in the same cycle, go to DECODE. Latency from the last lane filling to dec_start is 2 cycles.
- DECODE: wait for dec_done; dec_done in any other state is ignored.
  - On dec_done: biterr = popcount(dec_res); frame_err = dec_err | (biterr != 0).
  - Register both, go to ACCUM.
- ACCUM:
  - frames += 1.
  - frame_errs += frame_err.
  - bit_errs += biterr.
  - All counters saturate at all-ones.
  - If frames == MAX_FRAMES (or the early stop below triggers), go to REPORT; else go to FILL, or straight to LAUNCH if all lanes are already full.
- REPORT (1 cycle): drive the res_* fields and pulse res_valid. The res_* fields hold their values until the next REPORT.
- NEXT:
  - If snr_idx == snr_stop or snr_start > snr_stop: go to DONE (single point only when start > stop).
  - Otherwise snr_idx += 1, clear counters, flush partial lane contents (discard samples taken at the old SNR), go to FILL.
- DONE: busy = 0, done = 1.

Optional Feature:
BER_EARLY_STOP_EN:
- Defined: in ACCUM, reaching frame_errs == ERR_LIMIT also ends the SNR point; the REPORT fields carry the counts at that point.
- Undefined: ERR_LIMIT is unused and every SNR point runs exactly MAX_FRAMES frames.

Test Plan:
- Test parameters: FRAME_LEN=8, LANES=2, MAX_FRAMES=3, ERR_LIMIT=2.
- Basic launch: lane 0 fed 1,2,3,4 and lane 1 fed 5,6,7,8 -> dec_start 2 cycles after the last sample; dec_llr LLR order is 1..8.
- Clean sweep: start with snr 3..4, every dec_done with dec_res=0 and dec_err=0 -> two res_valid pulses, (snr 3, 3, 0, 0) then (snr 4, 3, 0, 0); then done=1 and busy=0.
- Error accounting: dec_res=8'b0000_0101, dec_err=0 on every frame -> res_frame_errs=3, res_bit_errs=6 (macro off); with BER_EARLY_STOP_EN -> res_frames=2, res_frame_errs=2, res_bit_errs=4.
- Overlap and backpressure: lanes full during DECODE -> lane_ce=0, extra samples dropped; dec_start fires 2 cycles after dec_done.
- Reset mid-DECODE: rst for one cycle -> all outputs 0; a later dec_done produces no res_valid; a new start works normally.
- Reversed range: snr_start=7, snr_stop=2 -> exactly one record, with res_snr=7.

Source files
------------

// File: rtl/ldpc_ber_sweep.sv
// BER sweep controller: fills a decoder frame from parallel noise lanes, drives the decoder
// handshake and accumulates frame/bit errors per SNR point. Macro BER_EARLY_STOP_EN enables early stop.

module ldpc_ber_lane #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         en,
    input  logic                         sample_valid,
    input  logic [DATA_W-1:0]            sample,
    output logic                         full,
    output logic [DEPTH-1:0][DATA_W-1:0] data
);
    localparam int FW = $clog2(DEPTH + 1);

    logic [FW-1:0] fill;

    assign full = (fill == FW'(DEPTH));

    // Sample j of the lane lands in slot j, so the frame layout falls out of the packed order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
            data <= '0;
        end else if (flush) begin
            fill <= '0;
        end else if (en && sample_valid && !full) begin
            for (int j = 0; j < DEPTH; j++)
                if (fill == FW'(j)) data[j] <= sample;
            fill <= fill + 1'b1;
        end
    end
endmodule

module ldpc_ber_sweep #(
    parameter int DATA_W     = 5,
    parameter int FRAME_LEN  = 2304,
    parameter int LANES      = 128,
    parameter int SNR_W      = 4,
    parameter int CNT_W      = 16,
    parameter int BITERR_W   = 24,
    parameter int MAX_FRAMES = 1000,
    parameter int ERR_LIMIT  = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [SNR_W-1:0]              snr_start,
    input  logic [SNR_W-1:0]              snr_stop,
    input  logic [LANES-1:0]              lane_valid,
    input  logic [LANES*DATA_W-1:0]       lane_llr,
    output logic [LANES-1:0]              lane_ce,
    output logic [SNR_W-1:0]              snr_idx,
    output logic                          dec_start,
    output logic [FRAME_LEN*DATA_W-1:0]   dec_llr,
    input  logic                          dec_done,
    input  logic [FRAME_LEN-1:0]          dec_res,
    input  logic                          dec_err,
    output logic                          res_valid,
    output logic [SNR_W-1:0]              res_snr,
    output logic [CNT_W-1:0]              res_frames,
    output logic [CNT_W-1:0]              res_frame_errs,
    output logic [BITERR_W-1:0]           res_bit_errs,
    output logic                          busy,
    output logic                          done
);
    localparam int LANE_DEPTH = FRAME_LEN / LANES;
    localparam int PW         = $clog2(FRAME_LEN + 1);
    localparam int BW1        = BITERR_W + 1;

    typedef enum logic [2:0] {IDLE, FILL, LAUNCH, DECODE, ACCUM, REPORT, NEXT, DONE} state_t;
    state_t state, state_nx;

    logic [LANES-1:0]                             full;
    logic [LANES-1:0][LANE_DEPTH-1:0][DATA_W-1:0] lane_data;
    logic                                         all_full, flush, load, stop_point, last_point;
    logic [SNR_W-1:0]                             snr_lo, snr_hi;
    logic [CNT_W-1:0]                             frames, frame_errs, frames_inc, frame_errs_inc;
    logic [BITERR_W-1:0]                          bit_errs, bit_errs_inc;
    logic [BW1-1:0]                               bit_sum;
    logic [PW-1:0]                                popcnt, biterr;
    logic                                         frame_err;

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign dec_start = (state == LAUNCH);
    assign res_valid = (state == REPORT);
    assign lane_ce   = busy ? ~full : '0;
    assign all_full  = &full;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ldpc_ber_lane #(.DATA_W(DATA_W), .DEPTH(LANE_DEPTH)) u_lane (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .en           (lane_ce[g]),
            .sample_valid (lane_valid[g]),
            .sample       (lane_llr[g*DATA_W +: DATA_W]),
            .full         (full[g]),
            .data         (lane_data[g])
        );
    end

    always_comb begin
        popcnt = '0;
        for (int k = 0; k < FRAME_LEN; k++)
            popcnt = popcnt + PW'(dec_res[k]);
    end

    assign frames_inc     = (&frames) ? frames : frames + 1'b1;
    assign frame_errs_inc = (frame_err && !(&frame_errs)) ? frame_errs + 1'b1 : frame_errs;
    assign bit_sum        = {1'b0, bit_errs} + BW1'(biterr);
    assign bit_errs_inc   = bit_sum[BITERR_W] ? '1 : bit_sum[BITERR_W-1:0];

`ifdef BER_EARLY_STOP_EN
    assign stop_point = (frames_inc == CNT_W'(MAX_FRAMES)) ||
                        (frame_errs_inc == CNT_W'(ERR_LIMIT));
`else
    assign stop_point = (frames_inc == CNT_W'(MAX_FRAMES));
    logic unused_err_limit;
    assign unused_err_limit = ^ERR_LIMIT;
`endif

    // A reversed range runs only the first point.
    assign last_point = (snr_idx == snr_hi) || (snr_lo > snr_hi);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = FILL;
            FILL:       if (all_full) state_nx = LAUNCH;
            LAUNCH:     state_nx = DECODE;
            DECODE:     if (dec_done) state_nx = ACCUM;
            ACCUM: begin
                if (stop_point)    state_nx = REPORT;
                else if (all_full) state_nx = LAUNCH;
                else               state_nx = FILL;
            end
            REPORT:     state_nx = NEXT;
            NEXT:       state_nx = last_point ? DONE : FILL;
            default:    state_nx = IDLE;
        endcase
    end

    // The frame is captured on the edge into LAUNCH so dec_llr is already valid with dec_start.
    assign load  = (state_nx == LAUNCH);
    assign flush = load || (((state == IDLE) || (state == DONE)) && start) ||
                   ((state == NEXT) && !last_point);

    always_ff @(posedge clk) begin
        if (rst) begin
            snr_lo         <= '0;
            snr_hi         <= '0;
            snr_idx        <= '0;
            frames         <= '0;
            frame_errs     <= '0;
            bit_errs       <= '0;
            biterr         <= '0;
            frame_err      <= 1'b0;
            dec_llr        <= '0;
            res_snr        <= '0;
            res_frames     <= '0;
            res_frame_errs <= '0;
            res_bit_errs   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        snr_lo     <= snr_start;
                        snr_hi     <= snr_stop;
                        snr_idx    <= snr_start;
                        frames     <= '0;
                        frame_errs <= '0;
                        bit_errs   <= '0;
                    end
                end
                DECODE: begin
                    if (dec_done) begin
                        biterr    <= popcnt;
                        frame_err <= dec_err || (popcnt != '0);
                    end
                end
                ACCUM: begin
                    frames     <= frames_inc;
                    frame_errs <= frame_errs_inc;
                    bit_errs   <= bit_errs_inc;
                    if (stop_point) begin
                        res_snr        <= snr_idx;
                        res_frames     <= frames_inc;
                        res_frame_errs <= frame_errs_inc;
                        res_bit_errs   <= bit_errs_inc;
                    end
                end
                NEXT: begin
                    if (!last_point) begin
                        snr_idx    <= snr_idx + 1'b1;
                        frames     <= '0;
                        frame_errs <= '0;
                        bit_errs   <= '0;
                    end
                end
                default: ;
            endcase
            if (load) dec_llr <= lane_data;
        end
    end
endmodule

// File: tb/tb_ldpc_ber_sweep.sv
// Directed bench for ldpc_ber_sweep with a small frame (8 LLRs over 2 lanes, 3 frames per point).
module tb_ldpc_ber_sweep;
    localparam int DATA_W = 5, FRAME_LEN = 8, LANES = 2, SNR_W = 4, CNT_W = 16;
    localparam int BITERR_W = 24, MAX_FRAMES = 3, ERR_LIMIT = 2;
`ifdef BER_EARLY_STOP_EN
    localparam int NF_ERR = 2;
`else
    localparam int NF_ERR = 3;
`endif

    logic                        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [SNR_W-1:0]            snr_start = '0, snr_stop = '0;
    logic [LANES-1:0]            lane_valid = '0;
    logic [LANES*DATA_W-1:0]     lane_llr = '0;
    logic [LANES-1:0]            lane_ce;
    logic [SNR_W-1:0]            snr_idx;
    logic                        dec_start;
    logic [FRAME_LEN*DATA_W-1:0] dec_llr;
    logic                        dec_done = 1'b0, dec_err = 1'b0;
    logic [FRAME_LEN-1:0]        dec_res = '0;
    logic                        res_valid, busy, done;
    logic [SNR_W-1:0]            res_snr;
    logic [CNT_W-1:0]            res_frames, res_frame_errs;
    logic [BITERR_W-1:0]         res_bit_errs;

    typedef struct packed {
        logic [SNR_W-1:0]    snr;
        logic [CNT_W-1:0]    frames;
        logic [CNT_W-1:0]    fe;
        logic [BITERR_W-1:0] be;
    } rec_t;

    rec_t recs[$];
    int   launches = 0;
    int   checks = 0, fails = 0;

    ldpc_ber_sweep #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .LANES(LANES), .SNR_W(SNR_W), .CNT_W(CNT_W),
        .BITERR_W(BITERR_W), .MAX_FRAMES(MAX_FRAMES), .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .snr_start(snr_start), .snr_stop(snr_stop),
        .lane_valid(lane_valid), .lane_llr(lane_llr), .lane_ce(lane_ce), .snr_idx(snr_idx),
        .dec_start(dec_start), .dec_llr(dec_llr), .dec_done(dec_done), .dec_res(dec_res),
        .dec_err(dec_err), .res_valid(res_valid), .res_snr(res_snr), .res_frames(res_frames),
        .res_frame_errs(res_frame_errs), .res_bit_errs(res_bit_errs), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (res_valid === 1'b1) recs.push_back({res_snr, res_frames, res_frame_errs, res_bit_errs});
        if (dec_start === 1'b1) launches++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; lane_valid = '0; dec_done = 1'b0; dec_res = '0; dec_err = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        recs.delete();
        launches = 0;
    endtask

    task automatic begin_sweep(input int lo, input int hi);
        snr_start = SNR_W'(lo);
        snr_stop  = SNR_W'(hi);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Lane 0 gets base..base+3, lane 1 gets base+4..base+7.
    task automatic feed_frame(input int base);
        for (int k = 0; k < 4; k++) begin
            lane_valid = '1;
            lane_llr   = {5'(base + 4 + k), 5'(base + k)};
            tick();
        end
        lane_valid = '0;
    endtask

    task automatic wait_launch(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (dec_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic serve_frame(input logic [7:0] res, input logic err);
        bit ok;
        feed_frame(1);
        wait_launch(ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL launch_timeout: dec_start not seen, want pulse within 12 cycles");
        end else begin
            tick();
            dec_res = res; dec_err = err; dec_done = 1'b1;
            tick();
            dec_done = 1'b0; dec_res = '0; dec_err = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (dec_start !== 1'b0) begin fails++; $display("FAIL rst_dec_start got %b want 0", dec_start); end
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
        checks++; if (dec_llr !== '0) begin fails++; $display("FAIL rst_dec_llr got %h want 0", dec_llr); end
        checks++; if (snr_idx !== '0) begin fails++; $display("FAIL rst_snr_idx got %0d want 0", snr_idx); end
        checks++;
        if ({res_snr, res_frames, res_frame_errs, res_bit_errs} !== '0) begin
            fails++; $display("FAIL rst_res_fields got %h want 0", {res_snr, res_frames, res_frame_errs, res_bit_errs});
        end
        rst = 1'b0;
        lane_valid = '1;
        tick();
        checks++; if (lane_ce !== 2'b00) begin fails++; $display("FAIL idle_lane_ce got %b want 00", lane_ce); end
        lane_valid = '0;
    endtask

    task automatic test_basic_launch();
        logic [FRAME_LEN*DATA_W-1:0] exp;
        for (int k = 0; k < FRAME_LEN; k++) exp[k*DATA_W +: DATA_W] = 5'(k + 1);
        do_reset();
        begin_sweep(0, 0);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
        checks++; if (lane_ce !== 2'b11) begin fails++; $display("FAIL basic_ce_open got %b want 11", lane_ce); end
        feed_frame(1);
        checks++; if (lane_ce !== 2'b00) begin fails++; $display("FAIL basic_ce_full got %b want 00", lane_ce); end
        checks++; if (dec_start !== 1'b0) begin fails++; $display("FAIL basic_early_start got %b want 0", dec_start); end
        tick();
        checks++; if (dec_start !== 1'b1) begin fails++; $display("FAIL basic_start_latency got %b want 1", dec_start); end
        checks++; if (dec_llr !== exp) begin fails++; $display("FAIL basic_llr_order got %h want %h", dec_llr, exp); end
        checks++; if (lane_ce !== 2'b11) begin fails++; $display("FAIL basic_ce_refill got %b want 11", lane_ce); end
    endtask

    task automatic test_clean_sweep();
        do_reset();
        begin_sweep(3, 4);
        serve_frame(8'h00, 1'b0);
        snr_start = 4'd9; snr_stop = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (snr_idx !== 4'd3) begin fails++; $display("FAIL clean_start_ignored got %0d want 3", snr_idx); end
        repeat (5) serve_frame(8'h00, 1'b0);
        repeat (2) tick();
        checks++;
        if (recs.size() !== 2) begin
            fails++; $display("FAIL clean_rec_count got %0d want 2", recs.size());
        end else begin
            checks++;
            if (recs[0] !== {4'd3, 16'd3, 16'd0, 24'd0}) begin
                fails++; $display("FAIL clean_rec0 got %h want %h", recs[0], {4'd3, 16'd3, 16'd0, 24'd0});
            end
            checks++;
            if (recs[1] !== {4'd4, 16'd3, 16'd0, 24'd0}) begin
                fails++; $display("FAIL clean_rec1 got %h want %h", recs[1], {4'd4, 16'd3, 16'd0, 24'd0});
            end
        end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL clean_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL clean_busy got %b want 0", busy); end
        checks++; if (launches !== 6) begin fails++; $display("FAIL clean_launches got %0d want 6", launches); end
    endtask

    task automatic test_error_accounting();
        rec_t exp;
`ifdef BER_EARLY_STOP_EN
        exp = {4'd5, 16'd2, 16'd2, 24'd4};
`else
        exp = {4'd5, 16'd3, 16'd3, 24'd6};
`endif
        do_reset();
        begin_sweep(5, 5);
        repeat (NF_ERR) serve_frame(8'b0000_0101, 1'b0);
        repeat (2) tick();
        checks++;
        if (recs.size() !== 1) begin
            fails++; $display("FAIL err_rec_count got %0d want 1", recs.size());
        end else begin
            checks++;
            if (recs[0] !== exp) begin fails++; $display("FAIL err_rec got %h want %h", recs[0], exp); end
        end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL err_done got %b want 1", done); end
    endtask

    task automatic test_overlap();
        bit ok;
        logic [FRAME_LEN*DATA_W-1:0] exp1, exp2;
        for (int k = 0; k < FRAME_LEN; k++) begin
            exp1[k*DATA_W +: DATA_W] = 5'(k + 1);
            exp2[k*DATA_W +: DATA_W] = 5'(k + 11);
        end
        do_reset();
        begin_sweep(0, 0);
        feed_frame(1);
        wait_launch(ok);
        checks++; if (!ok) begin fails++; $display("FAIL ovl_launch_timeout got none want dec_start"); end
        tick();
        feed_frame(11);
        checks++; if (lane_ce !== 2'b00) begin fails++; $display("FAIL ovl_ce_full got %b want 00", lane_ce); end
        lane_valid = 2'b11;
        lane_llr   = {5'd31, 5'd31};
        repeat (2) tick();
        lane_valid = '0;
        checks++; if (lane_ce !== 2'b00) begin fails++; $display("FAIL ovl_ce_hold got %b want 00", lane_ce); end
        checks++; if (dec_llr !== exp1) begin fails++; $display("FAIL ovl_llr_stable got %h want %h", dec_llr, exp1); end
        dec_done = 1'b1;
        tick();
        dec_done = 1'b0;
        checks++; if (dec_start !== 1'b0) begin fails++; $display("FAIL ovl_start_early got %b want 0", dec_start); end
        tick();
        checks++; if (dec_start !== 1'b1) begin fails++; $display("FAIL ovl_start_latency got %b want 1", dec_start); end
        checks++; if (dec_llr !== exp2) begin fails++; $display("FAIL ovl_llr_frame2 got %h want %h", dec_llr, exp2); end
    endtask

    task automatic test_reset_mid_decode();
        bit ok;
        do_reset();
        begin_sweep(2, 3);
        feed_frame(1);
        wait_launch(ok);
        checks++; if (!ok) begin fails++; $display("FAIL mid_launch_timeout got none want dec_start"); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (dec_llr !== '0) begin fails++; $display("FAIL mid_dec_llr got %h want 0", dec_llr); end
        checks++; if (snr_idx !== '0) begin fails++; $display("FAIL mid_snr_idx got %0d want 0", snr_idx); end
        checks++; if (lane_ce !== 2'b00) begin fails++; $display("FAIL mid_lane_ce got %b want 00", lane_ce); end
        dec_res = 8'hff; dec_done = 1'b1;
        tick();
        dec_done = 1'b0; dec_res = '0;
        repeat (5) tick();
        checks++; if (recs.size() !== 0) begin fails++; $display("FAIL mid_stray_rec got %0d want 0", recs.size()); end
        checks++; if (launches !== 1) begin fails++; $display("FAIL mid_stray_launch got %0d want 1", launches); end
        begin_sweep(1, 1);
        repeat (3) serve_frame(8'h00, 1'b0);
        repeat (2) tick();
        checks++;
        if (recs.size() !== 1) begin
            fails++; $display("FAIL mid_restart_count got %0d want 1", recs.size());
        end else begin
            checks++;
            if (recs[0] !== {4'd1, 16'd3, 16'd0, 24'd0}) begin
                fails++; $display("FAIL mid_restart_rec got %h want %h", recs[0], {4'd1, 16'd3, 16'd0, 24'd0});
            end
        end
    endtask

    task automatic test_reversed();
        rec_t exp;
`ifdef BER_EARLY_STOP_EN
        exp = {4'd7, 16'd2, 16'd2, 24'd0};
`else
        exp = {4'd7, 16'd3, 16'd3, 24'd0};
`endif
        do_reset();
        begin_sweep(7, 2);
        checks++; if (snr_idx !== 4'd7) begin fails++; $display("FAIL rev_snr_idx got %0d want 7", snr_idx); end
        repeat (NF_ERR) serve_frame(8'h00, 1'b1);
        repeat (4) tick();
        checks++;
        if (recs.size() !== 1) begin
            fails++; $display("FAIL rev_rec_count got %0d want 1", recs.size());
        end else begin
            checks++;
            if (recs[0] !== exp) begin fails++; $display("FAIL rev_rec got %h want %h", recs[0], exp); end
        end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL rev_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rev_busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic_launch();
        test_clean_sweep();
        test_error_accounting();
        test_overlap();
        test_reset_mid_decode();
        test_reversed();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
